// File: rtl/plab4_net_pkg.sv
// Shared ring-network definitions.
//   - Input port indices (bit positions in request/grant vectors).
//   - Crossbar select encodings.
//   - Default downstream queue depth.
//   - A helper that advances a mod-3 port index.
package plab4_net_pkg;

  localparam int EAST = 0;
  localparam int TERM = 1;
  localparam int WEST = 2;

  localparam logic [1:0] SEL_EAST = 2'd0;
  localparam logic [1:0] SEL_TERM = 2'd1;
  localparam logic [1:0] SEL_WEST = 2'd2;

  localparam int DEFAULT_NUM_ENTRIES = 2;

  // Next port index in the scan order 0 -> 1 -> 2 -> 0.
  function automatic logic [1:0] ptr_inc(input logic [1:0] idx);
    return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
  endfunction

endpackage

// File: rtl/plab4_net_rr_arb3.sv
// Three-input round-robin arbiter.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   en         : allow a grant this cycle
//   fire       : the granted message was accepted; advance the pointer
//   reqs[2:0]  : request per input port
//   grants[2:0]: one-hot grant (or zero), combinational
// The winner is the first requester at or after the priority pointer.
// On fire the pointer moves just past the winner, so it holds only 0..2.
module plab4_net_rr_arb3
  import plab4_net_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       fire,
  input  logic [2:0] reqs,
  output logic [2:0] grants
);

  logic [1:0] ptr_reg;
  logic [1:0] ptr_next;
  logic [1:0] win_idx;
  logic [1:0] idx;
  logic       found;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ptr_reg <= 2'd0;
    else       ptr_reg <= ptr_next;
  end

  always_comb begin
    grants  = 3'b000;
    win_idx = 2'd0;
    found   = 1'b0;
    idx     = ptr_reg;
    if (en) begin
      for (int k = 0; k < 3; k++) begin
        if (!found && reqs[idx]) begin
          grants[idx] = 1'b1;
          win_idx     = idx;
          found       = 1'b1;
        end
        idx = ptr_inc(idx);
      end
    end
  end

  assign ptr_next = fire ? ptr_inc(win_idx) : ptr_reg;

endmodule

// File: rtl/plab4_net_router_output_credit_ctrl.sv
// Per-output-port control for a ring router.
// Ports:
//   clk, reset    : clock, asynchronous active-high reset
//   reqs[2:0]     : requests from west[2], terminal[1], east[0] inputs
//   grants[2:0]   : one-hot grant or zero
//   sel[1:0]      : crossbar select (0 east, 1 terminal, 2 west; 0 idle)
//   out_val       : message presented downstream
//   out_rdy       : downstream accepts this cycle
//   credit_return : downstream queue freed one slot
//   num_free      : registered free-slot count of the downstream queue
module plab4_net_router_output_credit_ctrl
  import plab4_net_pkg::*;
#(
  parameter int p_num_entries   = DEFAULT_NUM_ENTRIES,
  parameter int p_num_free_nbits = 2,
  parameter bit p_credit_en     = 1'b1
)(
  input  logic                        clk,
  input  logic                        reset,
  input  logic [2:0]                  reqs,
  output logic [2:0]                  grants,
  output logic [1:0]                  sel,
  output logic                        out_val,
  input  logic                        out_rdy,
  input  logic                        credit_return,
  output logic [p_num_free_nbits-1:0] num_free
);

  localparam logic [p_num_free_nbits-1:0] NF_MAX = p_num_free_nbits'(p_num_entries);

  logic credit_ok;
  logic arb_en;
  logic fire;

  // Reset also blocks grants so nothing leaves while neighbours are clearing.
  assign arb_en  = out_rdy & credit_ok & ~reset;
  assign out_val = |grants;
  assign fire    = out_val;  // grants already require out_rdy

  plab4_net_rr_arb3 arb (
    .clk    (clk),
    .reset  (reset),
    .en     (arb_en),
    .fire   (fire),
    .reqs   (reqs),
    .grants (grants)
  );

  always_comb begin
    sel = SEL_EAST;
    if (grants[TERM]) sel = SEL_TERM;
    if (grants[WEST]) sel = SEL_WEST;
  end

  generate
    if (p_credit_en) begin : g_credit
      logic [p_num_free_nbits-1:0] num_free_reg;
      logic [p_num_free_nbits-1:0] num_free_next;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) num_free_reg <= NF_MAX;
        else       num_free_reg <= num_free_next;
      end

      // A return and a send in the same cycle cancel out. A return while
      // full is an upstream error; the count saturates rather than wrap.
      always_comb begin
        num_free_next = num_free_reg;
        case ({fire, credit_return})
          2'b10:   num_free_next = num_free_reg - 1'b1;
          2'b01:   if (num_free_reg != NF_MAX) num_free_next = num_free_reg + 1'b1;
          default: num_free_next = num_free_reg;
        endcase
      end

      assign credit_ok = (num_free_reg != '0);
      assign num_free  = num_free_reg;
    end else begin : g_no_credit
      assign credit_ok = 1'b1;
      assign num_free  = NF_MAX;
    end
  endgenerate

endmodule

// File: tb/tb_plab4_net_router_output_credit_ctrl.sv
module tb_plab4_net_router_output_credit_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] reqs;
  logic       out_rdy;
  logic       credit_return;

  // credit-tracking instance
  logic [2:0] grants1;
  logic [1:0] sel1;
  logic       out_val1;
  logic [1:0] num_free1;
  // terminal (no credit) instance
  logic [2:0] grants0;
  logic [1:0] sel0;
  logic       out_val0;
  logic [1:0] num_free0;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  plab4_net_router_output_credit_ctrl #(
    .p_num_entries(2), .p_num_free_nbits(2), .p_credit_en(1'b1)
  ) dut1 (
    .clk(clk), .reset(reset), .reqs(reqs), .grants(grants1), .sel(sel1),
    .out_val(out_val1), .out_rdy(out_rdy), .credit_return(credit_return),
    .num_free(num_free1)
  );

  plab4_net_router_output_credit_ctrl #(
    .p_num_entries(2), .p_num_free_nbits(2), .p_credit_en(1'b0)
  ) dut0 (
    .clk(clk), .reset(reset), .reqs(reqs), .grants(grants0), .sel(sel0),
    .out_val(out_val0), .out_rdy(out_rdy), .credit_return(credit_return),
    .num_free(num_free0)
  );

  // A credit returned while the counter is already full is an upstream error.
  always @(posedge clk) begin
    if (!reset)
      assert (!(credit_return && !out_val1 && num_free1 == 2'd2))
        else $error("credit returned with counter full");
  end

  typedef struct {
    logic [2:0] reqs;
    logic       rdy;
    logic       cr;
    logic [2:0] g1;
    logic [1:0] s1;
    logic [1:0] nf1;
    logic [2:0] g0;
  } vec_t;

  typedef struct {
    logic [2:0] g1;
    logic [1:0] s1;
    logic [1:0] nf1;
    logic [2:0] g0;
    logic [1:0] s0;
  } exp_t;

  vec_t vecs[19];
  exp_t exp_q[$];

  function automatic logic [1:0] sel_of(input logic [2:0] g);
    return g[2] ? 2'd2 : (g[1] ? 2'd1 : 2'd0);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    exp_t e;
    // reqs  rdy cr  grants1 sel1 nf1 grants0
    vecs[0]  = '{3'b111, 1'b1, 1'b1, 3'b001, 2'd0, 2'd2, 3'b001}; // fairness
    vecs[1]  = '{3'b111, 1'b1, 1'b1, 3'b010, 2'd1, 2'd2, 3'b010};
    vecs[2]  = '{3'b111, 1'b1, 1'b1, 3'b100, 2'd2, 2'd2, 3'b100};
    vecs[3]  = '{3'b111, 1'b1, 1'b1, 3'b001, 2'd0, 2'd2, 3'b001};
    vecs[4]  = '{3'b100, 1'b1, 1'b0, 3'b100, 2'd2, 2'd2, 3'b100}; // exhaustion
    vecs[5]  = '{3'b100, 1'b1, 1'b0, 3'b100, 2'd2, 2'd1, 3'b100};
    vecs[6]  = '{3'b100, 1'b1, 1'b0, 3'b000, 2'd0, 2'd0, 3'b100};
    vecs[7]  = '{3'b100, 1'b1, 1'b1, 3'b000, 2'd0, 2'd0, 3'b100}; // one return
    vecs[8]  = '{3'b100, 1'b1, 1'b0, 3'b100, 2'd2, 2'd1, 3'b100};
    vecs[9]  = '{3'b100, 1'b1, 1'b0, 3'b000, 2'd0, 2'd0, 3'b100};
    vecs[10] = '{3'b000, 1'b1, 1'b1, 3'b000, 2'd0, 2'd0, 3'b000};
    vecs[11] = '{3'b100, 1'b1, 1'b1, 3'b100, 2'd2, 2'd1, 3'b100}; // fire+return
    vecs[12] = '{3'b000, 1'b1, 1'b0, 3'b000, 2'd0, 2'd1, 3'b000};
    vecs[13] = '{3'b001, 1'b1, 1'b1, 3'b001, 2'd0, 2'd1, 3'b001}; // ptr -> 1
    vecs[14] = '{3'b011, 1'b0, 1'b0, 3'b000, 2'd0, 2'd1, 3'b000}; // backpressure
    vecs[15] = '{3'b011, 1'b0, 1'b0, 3'b000, 2'd0, 2'd1, 3'b000};
    vecs[16] = '{3'b011, 1'b1, 1'b0, 3'b010, 2'd1, 2'd1, 3'b010};
    vecs[17] = '{3'b011, 1'b1, 1'b1, 3'b000, 2'd0, 2'd0, 3'b001};
    vecs[18] = '{3'b011, 1'b1, 1'b0, 3'b001, 2'd0, 2'd1, 3'b010};

    // Reset with all requests pending: nothing granted.
    reset = 1'b1; reqs = 3'b111; out_rdy = 1'b1; credit_return = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); #2;
    check("rst_grants1", 32'(grants1), 32'(3'b000));
    check("rst_out_val1", 32'(out_val1), 32'(1'b0));
    check("rst_num_free1", 32'(num_free1), 32'(2'd2));
    check("rst_grants0", 32'(grants0), 32'(3'b000));
    $display("reset: grants1=%b out_val1=%b num_free1=%0d", grants1, out_val1, num_free1);
    @(negedge clk);
    reset = 1'b0; reqs = 3'b000;

    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      reqs = vecs[i].reqs; out_rdy = vecs[i].rdy; credit_return = vecs[i].cr;
      exp_q.push_back('{vecs[i].g1, vecs[i].s1, vecs[i].nf1, vecs[i].g0, sel_of(vecs[i].g0)});
      #2;
      e = exp_q.pop_front();
      $display("vec %0d: reqs=%b rdy=%b cr=%b -> g1=%b s1=%0d nf1=%0d g0=%b s0=%0d",
               i, reqs, out_rdy, credit_return, grants1, sel1, num_free1, grants0, sel0);
      check($sformatf("v%0d_grants1", i), 32'(grants1), 32'(e.g1));
      check($sformatf("v%0d_sel1", i), 32'(sel1), 32'(e.s1));
      check($sformatf("v%0d_out_val1", i), 32'(out_val1), 32'(|e.g1));
      check($sformatf("v%0d_num_free1", i), 32'(num_free1), 32'(e.nf1));
      check($sformatf("v%0d_grants0", i), 32'(grants0), 32'(e.g0));
      check($sformatf("v%0d_sel0", i), 32'(sel0), 32'(e.s0));
      check($sformatf("v%0d_num_free0", i), 32'(num_free0), 32'(2'd2));
    end

    // Mid-stream reset: counter empty, then reset between clock edges.
    @(negedge clk);
    reqs = 3'b111; out_rdy = 1'b0; credit_return = 1'b0;
    #2;
    check("mid_pre_num_free1", 32'(num_free1), 32'(2'd0));
    #1 reset = 1'b1;
    #1;
    check("mid_num_free1", 32'(num_free1), 32'(2'd2));
    check("mid_grants1", 32'(grants1), 32'(3'b000));
    $display("mid reset: num_free1=%0d grants1=%b", num_free1, grants1);
    @(negedge clk);
    reset = 1'b0; out_rdy = 1'b1; reqs = 3'b111;
    #2;
    check("post_grants1", 32'(grants1), 32'(3'b001));
    check("post_sel1", 32'(sel1), 32'(2'd0));
    check("post_num_free1", 32'(num_free1), 32'(2'd2));
    check("post_grants0", 32'(grants0), 32'(3'b001));
    $display("post reset: grants1=%b grants0=%b num_free1=%0d", grants1, grants0, num_free1);
    @(negedge clk);
    reqs = 3'b000;
    #2;
    check("post_dec_num_free1", 32'(num_free1), 32'(2'd1));
    $display("post fire: num_free1=%0d", num_free1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
